sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter NSPR, default 4: number of sprite channels, 1..8.
REQ-002 Parameter TAW, default 16: texture address width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 req  in  1  pixel-byte request strobe, sampled only in IDLE.
REQ-006 addrD  in  11  requested byte: addrD[10:6] = byte column, addrD[5:0] = display row.
REQ-007 dataD  out  8  composited byte, MSB = leftmost pixel, held until next result.
REQ-008 dvalid  out  1  one-cycle pulse: dataD updated.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 req_drop  out  1  one-cycle pulse: req arrived while busy.
REQ-011 spr_x  in  NSPR*16  per-channel signed left edge, in pixels.
REQ-012 spr_y  in  NSPR*16  per-channel signed bottom edge, in pixels.
REQ-013 spr_en  in  NSPR  per-channel enable.
REQ-014 game_state  in  2  mode: 00/01 normal, 10 invert, 11 blank.
REQ-015 addrT  out  TAW  texture ROM address.
REQ-016 rd_en  out  1  texture read strobe.
REQ-017 dataT  in  8  texture byte, valid the cycle after rd_en.

Function
REQ-018 On req in IDLE, capture a snapshot of addrD, spr_x, spr_y, spr_en and game_state; later input changes do not affect the result.
REQ-019 Coordinates: posx = addrD[10:6]*8 and posy = 63 - addrD[5:0], both unsigned and zero-extended to 16 bits.
REQ-020 Channel i hits when all hold: spr_en[i]; spr_x < posx+8; spr_x+W[i] > posx; spr_y <= posy < spr_y+H[i]; all comparisons are signed 17-bit.
REQ-021 States: IDLE, SEL, RD, CAP, OUT.
 - IDLE -> SEL on req.
 - In SEL, the lowest pending hit channel is chosen and cleared from the pending mask.
 - SEL -> OUT when no hit is pending, or when game_state=11.
 - Each needed fetch runs RD then CAP.
 - After the last fetch of a channel, CAP -> SEL.
 - OUT -> IDLE.
REQ-022 For each hit channel:
 - dx = posx - spr_x (signed); c0 = dx>>>3; s = dx[2:0]; row = spr_y + H - 1 - posy.
 - Fetch column c0 when s=0, otherwise columns c0 and c0+1.
 - Skip any column outside 0..W/8-1; skipped columns cost no cycles and contribute 0.
REQ-023 Fetch address: addrT = BASE[i] + H[i]*col + row, truncated to TAW bits.
REQ-024 In RD, drive rd_en=1 and addrT; in CAP, sample dataT. All other cycles: rd_en=0.
REQ-025 Contribution per fetch:
 - column c0: T << s.
 - column c0+1: T >> (8-s).
 - All contributions are ORed into an 8-bit accumulator, cleared on req.
REQ-026 In OUT, dataD = accumulator, or ~accumulator when game_state=10, or 0 when game_state=11; dvalid=1.
REQ-027 Latency: dvalid rises at T+2+sum(1+2*f_i), where T is the req cycle and f_i is the fetch count of hit channel i. Blank mode or zero hits gives T+2.
REQ-028 req while busy is ignored, pulses req_drop, and leaves the in-flight result unaffected.

Reset
REQ-029 rstn low, asynchronously:
 - state = IDLE.
 - dataD, accumulator, pending mask = 0.
 - dvalid, busy, req_drop, rd_en = 0.
 - addrT = 0.
REQ-030 Reset mid-operation abandons the request; the first req after release starts cleanly.

Structure
REQ-031 Shared package rex_pkg holds the state encoding, NSPR_MAX=8, and per-channel constant arrays:
 - W = {24,16,16,24}
 - H = {23,22,22,16}
 - BASE = {0,69,113,157}
REQ-032 One sub-module, spr_hit, instantiated NSPR times; it computes hit, c0, s, row and fetch-valid flags for one channel from the snapshot.

Verification
REQ-033 ch0 x=8 y=0, addrD=0x07F, dataT=0xA5 -> one RD with addrT=22; dataD=0xA5; dvalid at T+5.
REQ-034 ch0 x=10 y=0, addrD=0x07F, dataT=0xFF -> single fetch at addrT=22 (c0=-1 skipped); dataD=0x3F at T+5.
REQ-035 ch0 x=8 and ch1 x=8 y=0, addrD=0x07F, dataT=0x0F then 0xF0 -> reads at addrT 22 then 90; dataD=0xFF at T+8.
REQ-036 Same as REQ-033 with game_state=11 -> no rd_en; dataD=0x00 at T+2. With game_state=10 -> dataD=0x5A at T+5.
REQ-037 Second req at T+2 -> req_drop pulse at T+3; first result still 0xA5 at T+5. rstn low at T+3 -> all outputs 0; next req completes normally.

Source files
------------

// File: rtl/rex_pkg.sv
// Shared definitions for the sprite compositor: FSM encoding and per-channel sprite geometry.
package rex_pkg;

    localparam int NSPR_MAX = 8;

    typedef enum logic [2:0] {StIdle, StSel, StRd, StCap, StOut} state_e;

    // Channels 4..7 reuse the 0..3 shapes; BASE continues the packed texture ROM layout.
    localparam int SPR_W    [NSPR_MAX] = '{24, 16, 16, 24, 24, 16, 16, 24};
    localparam int SPR_H    [NSPR_MAX] = '{23, 22, 22, 16, 23, 22, 22, 16};
    localparam int SPR_BASE [NSPR_MAX] = '{0, 69, 113, 157, 205, 274, 318, 362};

    function automatic int fetch_addr(input int ch, input logic signed [16:0] col,
                                      input logic signed [16:0] row);
        return SPR_BASE[ch] + SPR_H[ch] * int'(col) + int'(row);
    endfunction

endpackage

// File: rtl/spr_hit.sv
// Per-channel hit test and fetch geometry for one 8-pixel display byte.
module spr_hit
    import rex_pkg::*;
#(
    parameter int CH = 0
) (
    input  logic               en,
    input  logic [15:0]        posx,
    input  logic [15:0]        posy,
    input  logic [15:0]        sx,
    input  logic [15:0]        sy,
    output logic               hit,
    output logic signed [16:0] c0,
    output logic [2:0]         s,
    output logic signed [16:0] row,
    output logic               fv0,
    output logic               fv1
);
    localparam int W    = SPR_W[CH];
    localparam int H    = SPR_H[CH];
    localparam int NCOL = W / 8;

    logic signed [16:0] px, py, x, y, dx, c1;

    assign px  = {1'b0, posx};
    assign py  = {1'b0, posy};
    assign x   = {sx[15], sx};
    assign y   = {sy[15], sy};

    assign hit = en && (x < px + 17'sd8) && (x + 17'(W) > px)
                 && (y <= py) && (py < y + 17'(H));

    assign dx  = px - x;
    assign c0  = dx >>> 3;
    assign c1  = c0 + 17'sd1;
    assign s   = dx[2:0];
    assign row = y + 17'(H) - 17'sd1 - py;

    // Columns outside the sprite are skipped entirely rather than read as zero.
    assign fv0 = hit && (c0 >= 17'sd0) && (c0 < 17'(NCOL));
    assign fv1 = hit && (s != 3'd0) && (c1 >= 17'sd0) && (c1 < 17'(NCOL));

endmodule

// File: rtl/sprite_compositor.sv
// Composites up to NSPR sprite channels into one display byte via sequential texture fetches.
module sprite_compositor
    import rex_pkg::*;
#(
    parameter int NSPR = 4,
    parameter int TAW  = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req,
    input  logic [10:0]        addrD,
    output logic [7:0]         dataD,
    output logic               dvalid,
    output logic               busy,
    output logic               req_drop,
    input  logic [NSPR*16-1:0] spr_x,
    input  logic [NSPR*16-1:0] spr_y,
    input  logic [NSPR-1:0]    spr_en,
    input  logic [1:0]         game_state,
    output logic [TAW-1:0]     addrT,
    output logic               rd_en,
    input  logic [7:0]         dataT
);
    state_e              state_q;
    logic [10:0]         addr_q;
    logic [NSPR*16-1:0]  x_q, y_q;
    logic [NSPR-1:0]     en_q;
    logic [1:0]          gs_q;
    logic [NSPR_MAX-1:0] pend_q;
    logic [7:0]          acc_q;
    logic [2:0]          sel_q;
    logic                phase_q;

    logic [15:0]         posx, posy;
    logic [NSPR_MAX-1:0] hit, fv0, fv1, cand;
    logic signed [16:0]  c0  [NSPR_MAX];
    logic signed [16:0]  row [NSPR_MAX];
    logic [2:0]          s   [NSPR_MAX];

    assign posx = {8'd0, addr_q[10:6], 3'd0};
    assign posy = {10'd0, 6'd63 - addr_q[5:0]};

    for (genvar i = 0; i < NSPR_MAX; i++) begin : g_ch
        if (i < NSPR) begin : g_on
            spr_hit #(.CH(i)) u_hit (
                .en   (en_q[i]),
                .posx (posx),
                .posy (posy),
                .sx   (x_q[i*16 +: 16]),
                .sy   (y_q[i*16 +: 16]),
                .hit  (hit[i]),
                .c0   (c0[i]),
                .s    (s[i]),
                .row  (row[i]),
                .fv0  (fv0[i]),
                .fv1  (fv1[i])
            );
        end else begin : g_off
            assign hit[i] = 1'b0;
            assign fv0[i] = 1'b0;
            assign fv1[i] = 1'b0;
            assign c0[i]  = '0;
            assign s[i]   = '0;
            assign row[i] = '0;
        end
    end

    logic [2:0]         pick;
    logic signed [16:0] col_sel;
    logic [TAW-1:0]     addr_sel, addr_nxt;
    logic [7:0]         contrib, out_byte;

    always_comb begin
        cand = pend_q & hit;
        pick = '0;
        for (int i = NSPR_MAX - 1; i >= 0; i--) begin
            if (cand[i]) pick = 3'(i);
        end
        col_sel  = fv0[pick] ? c0[pick] : c0[pick] + 17'sd1;
        addr_sel = TAW'(fetch_addr(int'(pick), col_sel, row[pick]));
        addr_nxt = TAW'(fetch_addr(int'(sel_q), c0[sel_q] + 17'sd1, row[sel_q]));
        // Left column contributes its right part shifted up; the right column its left part.
        contrib  = phase_q ? (dataT >> (4'd8 - {1'b0, s[sel_q]})) : (dataT << s[sel_q]);
        case (gs_q)
            2'b11:   out_byte = 8'h00;
            2'b10:   out_byte = ~acc_q;
            default: out_byte = acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            en_q     <= '0;
            gs_q     <= '0;
            pend_q   <= '0;
            acc_q    <= '0;
            sel_q    <= '0;
            phase_q  <= 1'b0;
            dataD    <= '0;
            dvalid   <= 1'b0;
            busy     <= 1'b0;
            req_drop <= 1'b0;
            rd_en    <= 1'b0;
            addrT    <= '0;
        end else begin
            dvalid   <= 1'b0;
            req_drop <= req && (state_q != StIdle);
            case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q  <= addrD;
                        x_q     <= spr_x;
                        y_q     <= spr_y;
                        en_q    <= spr_en;
                        gs_q    <= game_state;
                        pend_q  <= '1;
                        acc_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StSel;
                    end
                end
                StSel: begin
                    if (gs_q == 2'b11 || cand == '0) begin
                        dataD   <= out_byte;
                        dvalid  <= 1'b1;
                        state_q <= StOut;
                    end else begin
                        pend_q[pick] <= 1'b0;
                        sel_q        <= pick;
                        if (fv0[pick] || fv1[pick]) begin
                            phase_q <= !fv0[pick];
                            addrT   <= addr_sel;
                            rd_en   <= 1'b1;
                            state_q <= StRd;
                        end
                    end
                end
                StRd: begin
                    rd_en   <= 1'b0;
                    state_q <= StCap;
                end
                StCap: begin
                    acc_q <= acc_q | contrib;
                    if (!phase_q && fv1[sel_q]) begin
                        phase_q <= 1'b1;
                        addrT   <= addr_nxt;
                        rd_en   <= 1'b1;
                        state_q <= StRd;
                    end else begin
                        state_q <= StSel;
                    end
                end
                StOut: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed, table-driven bench for sprite_compositor with a small address-keyed texture ROM.
module tb_sprite_compositor;
    localparam int NSPR = 4;
    localparam int TAW  = 16;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               req = 1'b0;
    logic [10:0]        addrD = '0;
    logic [7:0]         dataD;
    logic               dvalid, busy, req_drop, rd_en;
    logic [NSPR*16-1:0] spr_x = '0;
    logic [NSPR*16-1:0] spr_y = '0;
    logic [NSPR-1:0]    spr_en = '0;
    logic [1:0]         game_state = '0;
    logic [TAW-1:0]     addrT;
    logic [7:0]         dataT = '0;

    logic [15:0] rom_a0 = '0, rom_a1 = '0;
    logic [7:0]  rom_d0 = '0, rom_d1 = '0;

    int errors = 0;
    int checks = 0;

    sprite_compositor #(.NSPR(NSPR), .TAW(TAW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .addrD      (addrD),
        .dataD      (dataD),
        .dvalid     (dvalid),
        .busy       (busy),
        .req_drop   (req_drop),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_en     (spr_en),
        .game_state (game_state),
        .addrT      (addrT),
        .rd_en      (rd_en),
        .dataT      (dataT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) dataT <= (addrT == rom_a0) ? rom_d0 : (addrT == rom_a1) ? rom_d1 : 8'h00;
        else       dataT <= 8'h00;
    end

    typedef struct {
        logic [63:0] xs;
        logic [63:0] ys;
        logic [3:0]  en;
        logic [1:0]  gs;
        logic [10:0] ad;
        logic [15:0] ra0;
        logic [7:0]  rd0;
        logic [15:0] ra1;
        logic [7:0]  rd1;
        int          nrd;
        logic [15:0] ea0;
        logic [15:0] ea1;
        int          lat;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic [63:0] xs, input logic [3:0] en, input logic [1:0] gs,
                                input logic [10:0] ad, input logic [15:0] ra0,
                                input logic [7:0] rd0, input logic [15:0] ra1,
                                input logic [7:0] rd1, input int nrd, input logic [15:0] ea0,
                                input logic [15:0] ea1, input int lat, input logic [7:0] data);
        vec_t v;
        v.xs = xs;   v.ys = 64'h0; v.en = en;   v.gs = gs;   v.ad = ad;
        v.ra0 = ra0; v.rd0 = rd0;  v.ra1 = ra1; v.rd1 = rd1; v.nrd = nrd;
        v.ea0 = ea0; v.ea1 = ea1;  v.lat = lat; v.data = data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        spr_x = v.xs; spr_y = v.ys; spr_en = v.en; game_state = v.gs; addrD = v.ad;
        rom_a0 = v.ra0; rom_d0 = v.rd0; rom_a1 = v.ra1; rom_d1 = v.rd1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [15:0] seen [4];
        int          nrd, cyc, lat;
        logic        got, b;
        logic [7:0]  d;
        for (int k = 0; k < 4; k++) seen[k] = 16'hFFFF;
        nrd = 0; cyc = 0; lat = 0; got = 1'b0; b = 1'b0; d = '0;
        @(negedge clk);
        apply(v);
        req = 1'b1;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            req = 1'b0;
            if (rd_en) begin
                if (nrd < 4) seen[nrd] = addrT;
                nrd++;
            end
            if (dvalid) begin
                got = 1'b1; lat = cyc; d = dataD; b = busy;
            end
        end
        check($sformatf("v%0d done", idx), 32'(got), 32'd1);
        check($sformatf("v%0d data", idx), 32'(d), 32'(v.data));
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d reads", idx), 32'(nrd), 32'(v.nrd));
        if (v.nrd > 0) check($sformatf("v%0d addr0", idx), 32'(seen[0]), 32'(v.ea0));
        if (v.nrd > 1) check($sformatf("v%0d addr1", idx), 32'(seen[1]), 32'(v.ea1));
        check($sformatf("v%0d busy_at_valid", idx), 32'(b), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d dvalid_pulse", idx), 32'(dvalid), 32'd0);
        check($sformatf("v%0d busy_after", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic got;
        logic [7:0] d;
        int   lat;

        //        xs                    en    gs     ad      ra0  rd0    ra1  rd1  n  ea0  ea1 lat data
        vecs[0]  = mk(64'h0008,          4'h1, 2'b00, 11'h07F, 22, 8'hA5, 0,   0,    1, 22,  0,  5, 8'hA5);
        vecs[1]  = mk(64'h000A,          4'h1, 2'b00, 11'h07F, 22, 8'hFF, 0,   0,    1, 22,  0,  5, 8'h3F);
        vecs[2]  = mk(64'h0008_0008,     4'h3, 2'b00, 11'h07F, 22, 8'h0F, 90,  8'hF0, 2, 22, 90, 8, 8'hFF);
        vecs[3]  = mk(64'h0008,          4'h1, 2'b11, 11'h07F, 22, 8'hA5, 0,   0,    0, 0,   0,  2, 8'h00);
        vecs[4]  = mk(64'h0008,          4'h1, 2'b10, 11'h07F, 22, 8'hA5, 0,   0,    1, 22,  0,  5, 8'h5A);
        vecs[5]  = mk(64'h0064,          4'h1, 2'b00, 11'h07F, 22, 8'hA5, 0,   0,    0, 0,   0,  2, 8'h00);
        vecs[6]  = mk(64'h0004,          4'h1, 2'b00, 11'h07F, 22, 8'hF1, 45,  8'h9C, 2, 22, 45, 7, 8'h19);
        vecs[7]  = mk(64'h0064,          4'h1, 2'b10, 11'h07F, 22, 8'hA5, 0,   0,    0, 0,   0,  2, 8'hFF);
        vecs[8]  = mk(64'h0008,          4'h1, 2'b00, 11'h069, 0,  8'h3C, 99,  0,    1, 0,   0,  5, 8'h3C);
        vecs[9]  = mk(64'h0008,          4'h1, 2'b00, 11'h068, 0,  8'h3C, 99,  0,    0, 0,   0,  2, 8'h00);
        vecs[10] = mk(64'h0000,          4'h1, 2'b00, 11'h0BF, 68, 8'h81, 0,   0,    1, 68,  0,  5, 8'h81);
        vecs[11] = mk(64'h0004,          4'h1, 2'b00, 11'h0FF, 68, 8'h77, 0,   0,    1, 68,  0,  5, 8'h70);
        vecs[12] = mk(64'hFFF8_0000,     4'h2, 2'b00, 11'h03F, 112, 8'h42, 0,  0,    1, 112, 0,  5, 8'h42);
        vecs[13] = mk(64'h0008_0000_0000_0000, 4'h8, 2'b00, 11'h07F, 172, 8'hC3, 0, 0, 1, 172, 0, 5, 8'hC3);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset dataD", 32'(dataD), 32'd0);
        check("reset dvalid", 32'(dvalid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset req_drop", 32'(req_drop), 32'd0);
        check("reset rd_en", 32'(rd_en), 32'd0);
        check("reset addrT", 32'(addrT), 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Request while busy: dropped, and inputs changed mid-flight must not leak in.
        @(negedge clk);
        apply(vecs[0]);
        req = 1'b1;
        cyc = 0; got = 1'b0; d = '0; lat = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            req = 1'b0;
            if (cyc >= 2 && cyc <= 4)
                check($sformatf("drop req_drop c%0d", cyc), 32'(req_drop), 32'(cyc == 3));
            if (cyc == 2) begin
                req = 1'b1; addrD = 11'h000; spr_x = '0; spr_en = 4'hF; game_state = 2'b11;
            end
            if (dvalid) begin
                got = 1'b1; d = dataD; lat = cyc;
            end
        end
        check("drop done", 32'(got), 32'd1);
        check("drop data", 32'(d), 32'hA5);
        check("drop latency", 32'(lat), 32'd5);
        @(negedge clk);

        // Asynchronous reset in the middle of a fetch.
        @(negedge clk);
        apply(vecs[0]);
        req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req = 1'b0;
        end
        rstn = 1'b0;
        #1;
        check("midrst dataD", 32'(dataD), 32'd0);
        check("midrst dvalid", 32'(dvalid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst req_drop", 32'(req_drop), 32'd0);
        check("midrst rd_en", 32'(rd_en), 32'd0);
        check("midrst addrT", 32'(addrT), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_vec(100, vecs[0]);
        run_vec(101, vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
